// File: rtl/sgpr_arb_pkg.sv
// Shared constants for the SGPR write-port arbiter and its requesters.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: requester index map, SGPR index width, word-enable encodings,
//           and the round-robin pointer advance helper.
package sgpr_arb_pkg;

   // Requester bit positions in req_valid / req_hold / grant
   localparam int REQ_SALU = 0;
   localparam int REQ_VALU = 1;
   localparam int REQ_LSU  = 2;

   // SGPR index width, matches dst_reg[8:0]
   localparam int SGPR_ADDR_W = 9;

   // Word enables, {hi,lo}
   localparam logic [1:0] WORD_EN_NONE = 2'b00;
   localparam logic [1:0] WORD_EN_LO   = 2'b01;
   localparam logic [1:0] WORD_EN_HI   = 2'b10;
   localparam logic [1:0] WORD_EN_64   = 2'b11;

   // Pointer value after granting index w: one past the winner, wrapping at n.
   function automatic int rr_next(input int w, input int n);
      return (w == n - 1) ? 0 : w + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot picker (shared by SGPR and VGPR write ports).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; losers are identified by req & ~win in the caller.
// Ports: req  - request vector, bit i = requester i
//        ptr  - index where the scan starts; caller keeps it below N
//        win  - one-hot winner, all zero when req is zero
module rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     win
);

   int   idx;
   logic found;

   // Walk the N positions starting at ptr; the first set request wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sgpr_wr_arbiter.sv
// SGPR write-port arbiter: round-robin among SALU / VALU / LSU write requests.
// Latency: 1 cycle from winning request to registered SGPR write port.
// Backpressure: losers see req_hold combinationally in the same cycle and must
//               keep valid/addr/data/wr_en stable until granted.
// Ports: clk, rst (async, active-high)
//        req_valid/req_addr/req_data/req_wr_en - packed per-requester requests
//        req_hold  - combinational stall per requester (held by rst as well)
//        grant     - registered one-hot owner of the current write-port cycle
//        sgpr_wr_en/sgpr_wr_addr/sgpr_wr_data - registered SGPR write port
//        conflict_cnt - saturating count of multi-request cycles, only when
//                       SGPR_ARB_STATS_EN is defined
module sgpr_wr_arbiter
   import sgpr_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = SGPR_ADDR_W,
   parameter int DATA_W  = 64,
   parameter int PTR_W   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ*2-1:0]      req_wr_en,
   output logic [NUM_REQ-1:0]        req_hold,
   output logic [NUM_REQ-1:0]        grant,
   output logic [1:0]                sgpr_wr_en,
   output logic [ADDR_W-1:0]         sgpr_wr_addr,
   output logic [DATA_W-1:0]         sgpr_wr_data
`ifdef SGPR_ARB_STATS_EN
   ,
   output logic [15:0]               conflict_cnt
`endif
);

   logic [NUM_REQ-1:0] win;
   logic               any_win;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_nxt;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic [1:0]         sel_en;

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .win (win)
   );

   assign any_win = |win;

   // While in reset nothing is granted, so every active requester is stalled.
   assign req_hold = rst ? req_valid : (req_valid & ~win);

   // Winner mux and pointer advance; win is one-hot so at most one slot matches.
   always_comb begin
      sel_addr   = '0;
      sel_data   = '0;
      sel_en     = WORD_EN_NONE;
      rr_ptr_nxt = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
            sel_data   = req_data[i*DATA_W +: DATA_W];
            sel_en     = req_wr_en[i*2 +: 2];
            rr_ptr_nxt = PTR_W'(rr_next(i, NUM_REQ));
         end
      end
   end

   // Async reset also kills a write that is already sitting in the port register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant        <= '0;
         sgpr_wr_en   <= WORD_EN_NONE;
         sgpr_wr_addr <= '0;
         sgpr_wr_data <= '0;
         rr_ptr       <= '0;
      end else begin
         grant      <= win;
         sgpr_wr_en <= any_win ? sel_en : WORD_EN_NONE;
         // Address/data only move on a real grant so an idle port stays quiet.
         if (any_win) begin
            sgpr_wr_addr <= sel_addr;
            sgpr_wr_data <= sel_data;
         end
         rr_ptr <= rr_ptr_nxt;
      end
   end

`ifdef SGPR_ARB_STATS_EN
   // Cycles where two or more requesters competed for the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (($countones(req_valid) > 1) && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sgpr_wr_arbiter.sv
// Self-checking bench for sgpr_wr_arbiter: scoreboard of expected port writes.
// Latency: expected entries are pushed at drive time and popped one cycle later.
// Backpressure: stimulus keeps held requesters stable; a protocol assertion guards it.
module tb_sgpr_wr_arbiter;

   localparam int N  = 3;
   localparam int AW = 9;
   localparam int DW = 64;

   typedef struct packed {
      logic [N-1:0]  g;
      logic [1:0]    en;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N*2-1:0]  req_wr_en;
   logic [N-1:0]    req_hold;
   logic [N-1:0]    grant;
   logic [1:0]      sgpr_wr_en;
   logic [AW-1:0]   sgpr_wr_addr;
   logic [DW-1:0]   sgpr_wr_data;
`ifdef SGPR_ARB_STATS_EN
   logic [15:0]     conflict_cnt;
`endif

   sgpr_wr_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_wr_en    (req_wr_en),
      .req_hold     (req_hold),
      .grant        (grant),
      .sgpr_wr_en   (sgpr_wr_en),
      .sgpr_wr_addr (sgpr_wr_addr),
      .sgpr_wr_data (sgpr_wr_data)
`ifdef SGPR_ARB_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Stimulus staging, one slot per requester
   logic [N-1:0]  tv;
   logic [AW-1:0] ta [N];
   logic [DW-1:0] td [N];
   logic [1:0]    te [N];

   // Reference model state
   int            m_ptr;
   logic [N-1:0]  m_win;
   logic [N-1:0]  m_hold;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_cnt;
   int            wait_c [N];
   int            max_wait;
   exp_t          sb [$];

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      req_valid = tv;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = ta[i];
         req_data[i*DW +: DW] = td[i];
         req_wr_en[i*2 +: 2]  = te[i];
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_hold = '0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = 0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
   endtask

   // One arbitration cycle: drive at negedge, check hold, push expectation,
   // then pop and compare the registered port after the next rising edge.
   task automatic step();
      exp_t e;
      exp_t o;
      int   w;
      int   idx;
      @(negedge clk);
      apply();
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (w < 0 && tv[idx]) w = idx;
      end
      m_win  = (w >= 0) ? N'(1) << w : '0;
      m_hold = tv & ~m_win;
      chk("req_hold", 64'(req_hold), 64'(m_hold));
      e.en = 2'b00;
      if (w >= 0) begin
         m_addr = ta[w];
         m_data = td[w];
         e.en   = te[w];
         m_ptr  = (w + 1) % N;
      end
      e.g = m_win;
      e.a = m_addr;
      e.d = m_data;
      sb.push_back(e);
      if ($countones(tv) >= 2 && m_cnt < 16'hFFFF) m_cnt++;
      for (int i = 0; i < N; i++) begin
         wait_c[i] = m_hold[i] ? wait_c[i] + 1 : 0;
         if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_underflow", 64'(1), 64'(0));
      end else begin
         o = sb.pop_front();
         chk("grant", 64'(grant), 64'(o.g));
         chk("wr_en", 64'(sgpr_wr_en), 64'(o.en));
         chk("wr_addr", 64'(sgpr_wr_addr), 64'(o.a));
         chk("wr_data", sgpr_wr_data, o.d);
      end
   endtask

   // Let held requesters finish; granted ones drop out.
   task automatic drain();
      int guard;
      guard = 0;
      while (m_hold != '0 && guard < 2 * N) begin
         tv = m_hold;
         step();
         guard++;
      end
      chk("drain", 64'(m_hold), 64'(0));
   endtask

   task automatic clear_slots();
      tv = '0;
      for (int i = 0; i < N; i++) begin
         ta[i] = '0;
         td[i] = '0;
         te[i] = 2'b00;
      end
   endtask

   // Held requester must keep valid, addr, data and wr_en stable.
   logic [N-1:0]    p_hold = '0;
   logic [N*AW-1:0] p_addr;
   logic [N*DW-1:0] p_data;
   logic [N*2-1:0]  p_en;
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (p_hold[i]) begin
               assert (req_valid[i] &&
                       req_addr[i*AW +: AW] == p_addr[i*AW +: AW] &&
                       req_data[i*DW +: DW] == p_data[i*DW +: DW] &&
                       req_wr_en[i*2 +: 2]  == p_en[i*2 +: 2])
               else $error("protocol violation by held requester %0d", i);
            end
         end
      end
      p_hold <= rst ? '0 : req_hold;
      p_addr <= req_addr;
      p_data <= req_data;
      p_en   <= req_wr_en;
   end

   initial begin
      max_wait = 0;
      model_reset();
      clear_slots();

      // Reset state; every active requester is held during reset
      rst = 1'b1;
      tv  = 3'b101;
      apply();
      #7;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_wr_en", 64'(sgpr_wr_en), 64'(0));
      chk("rst_addr", 64'(sgpr_wr_addr), 64'(0));
      chk("rst_data", sgpr_wr_data, 64'(0));
      chk("rst_ptr", 64'(dut.rr_ptr), 64'(0));
      chk("rst_hold", 64'(req_hold), 64'(3'b101));
      @(negedge clk);
      clear_slots();
      apply();
      rst = 1'b0;

      // Single SALU low-word write
      tv = 3'b001; ta[0] = 9'h010; td[0] = 64'hDEADBEEF; te[0] = 2'b01;
      step();
      clear_slots();

      // 64-bit LSU write moves the pointer back to 0
      tv = 3'b100; ta[2] = 9'h020; td[2] = 64'h1122334455667788; te[2] = 2'b11;
      step();
      chk("ptr_after_lsu", 64'(dut.rr_ptr), 64'(0));

      // All three valid from ptr 0: grants 001, 010, 100
      ta[0] = 9'h041; td[0] = 64'hA0A0; te[0] = 2'b01;
      ta[1] = 9'h042; td[1] = 64'hB1B1; te[1] = 2'b10;
      ta[2] = 9'h043; td[2] = 64'hC2C2; te[2] = 2'b11;
      tv = 3'b111; step();
      tv = 3'b110; step();
      tv = 3'b100; step();
      clear_slots();

      // Degenerate VALU request (wr_en 00) still takes the slot -> ptr 2
      tv = 3'b010; ta[1] = 9'h0FF; td[1] = 64'h5555; te[1] = 2'b00;
      step();
      chk("ptr_after_degen", 64'(dut.rr_ptr), 64'(2));
      clear_slots();

      // From ptr 2, req 0 and req 2: LSU first, then SALU after wrap
      ta[0] = 9'h011; td[0] = 64'h0000_0000_0000_0011; te[0] = 2'b01;
      ta[2] = 9'h022; td[2] = 64'h2200_0000_0000_0000; te[2] = 2'b10;
      tv = 3'b101; step();
      tv = 3'b001; step();
      chk("ptr_after_wrap", 64'(dut.rr_ptr), 64'(1));

      // Reset asserted mid-cycle: pending SALU write and registered write both dropped
      @(negedge clk);
      clear_slots();
      tv = 3'b001; ta[0] = 9'h005; td[0] = 64'hA; te[0] = 2'b01;
      apply();
      #2 rst = 1'b1;
      #1;
      chk("midrst_hold", 64'(req_hold), 64'(3'b001));
      chk("midrst_wr_en_now", 64'(sgpr_wr_en), 64'(0));
      @(posedge clk);
      #1;
      chk("midrst_wr_en", 64'(sgpr_wr_en), 64'(0));
      chk("midrst_grant", 64'(grant), 64'(0));
      chk("midrst_ptr", 64'(dut.rr_ptr), 64'(0));
      @(negedge clk);
      clear_slots();
      apply();
      rst = 1'b0;
      model_reset();

      // Same address from SALU and VALU: serialized, later grant overwrites
      ta[0] = 9'h030; td[0] = 64'h1111; te[0] = 2'b11;
      ta[1] = 9'h030; td[1] = 64'h2222; te[1] = 2'b11;
      tv = 3'b011; step();
      tv = 3'b010; step();
      clear_slots();

      // Idle cycle: no grant, addr/data hold
      step();

      // Back-to-back VALU, granted every cycle
      for (int c = 0; c < 4; c++) begin
         tv = 3'b010; ta[1] = AW'(9'h100 + c); td[1] = {$urandom, $urandom}; te[1] = 2'b01;
         step();
      end

      // Random traffic honoring the hold rule
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_hold[i]) begin
               tv[i] = ($urandom_range(0, 99) < 60);
               ta[i] = AW'($urandom);
               td[i] = {$urandom, $urandom};
               te[i] = 2'($urandom_range(0, 3));
            end
         end
         step();
      end
      drain();
      chk("fairness", 64'(max_wait), 64'(N - 1));

`ifdef SGPR_ARB_STATS_EN
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      // Saturation near the top of the counter
      @(negedge clk);
      force dut.conflict_cnt = 16'hFFFD;
      #1 release dut.conflict_cnt;
      m_cnt = 16'hFFFD;
      ta[0] = 9'h001; ta[1] = 9'h002; ta[2] = 9'h003;
      tv = 3'b111; step();
      drain();
      tv = 3'b011; step();
      drain();
      chk("conflict_sat", 64'(conflict_cnt), 64'(16'hFFFF));
      chk("conflict_model", 64'(conflict_cnt), 64'(m_cnt));
`endif

      clear_slots();
      step();
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Overall time limit
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sgpr_wr_arbiter.md
Name: sgpr_wr_arbiter

Overview:
- SGPR write-port arbiter on the register-file side; it answers the `salu2sgpr_req` request line.
- Accepts write requests from NUM_REQ requesters: bit 0 = SALU, bit 1 = VALU (VCC/compare results), bit 2 = LSU scalar loads.
- Grants one requester per cycle, round-robin, and drives the single SGPR write port one cycle later.
- Tells every losing requester to stall via the `req_hold` lines (the `rfa2salu_req_hold` family).

Parameters:
NUM_REQ, 3, number of requesters; legal range 2..8.
ADDR_W, 9, SGPR index width, equal to dst_reg[8:0].
DATA_W, 64, write data width; low word = [31:0], high word = [63:32].
PTR_W, 3, round-robin pointer width; must satisfy 2**PTR_W >= NUM_REQ.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester write request; bit 0 is salu2sgpr_req.
req_addr  input  NUM_REQ*ADDR_W  packed SGPR indices; requester i occupies slice [i*ADDR_W +: ADDR_W].
req_data  input  NUM_REQ*DATA_W  packed write data.
req_wr_en  input  NUM_REQ*2  packed word enables, {hi,lo}.
req_hold  output  NUM_REQ  combinational stall to requester i; bit 0 is rfa2salu_req_hold.
grant  output  NUM_REQ  registered one-hot; identifies the owner of the current write-port cycle.
sgpr_wr_en  output  2  registered word enables to the SGPR file.
sgpr_wr_addr  output  ADDR_W  registered SGPR index.
sgpr_wr_data  output  DATA_W  registered write data.
conflict_cnt  output  16  optional; present only with SGPR_ARB_STATS_EN.

Behaviour:
- Reset (rst=1, async):
  - grant=0, sgpr_wr_en=0, sgpr_wr_addr=0, sgpr_wr_data=0, rr_ptr=0, conflict_cnt=0.
  - While rst is high, req_hold = req_valid, so every requester is held.
  - A registered write in flight when rst asserts is dropped and never reaches the SGPR file.
- Arbitration (combinational, cycle t):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner; win is one-hot, or zero if no request.
- Hold:
  - req_hold[i] = req_valid[i] & ~win[i], valid in the same cycle.
  - Requesters with req_valid=0 never see hold.
- Requester rule while held:
  - Keep req_valid=1 and keep addr, data and wr_en stable into the next cycle.
  - Dropping or changing them while held is a protocol violation; the bench flags it with an assertion.
- Register stage (edge ending cycle t):
  - grant <= win.
  - sgpr_wr_en <= winner wr_en, or 2'b00 if no winner.
  - sgpr_wr_addr and sgpr_wr_data <= winner's slices.
  - When there is no winner, addr and data hold their previous values.
  - Latency from request to SGPR write is 1 cycle for the winner; the write is visible on the port in cycle t+1.
- Pointer:
  - On a winner at index w, rr_ptr <= (w+1) mod NUM_REQ.
  - With no winner, rr_ptr is unchanged.
  - Wrap at NUM_REQ-1 returns to 0; the pointer never holds a value >= NUM_REQ.
- Fairness: a continuously held requester is granted within NUM_REQ cycles.
- Degenerate requests:
  - req_valid with wr_en=2'b00 still wins and consumes the slot; the port sees sgpr_wr_en=00.
  - A 64-bit write (wr_en=11) consumes one slot, not two.
- Ordering:
  - Two requesters targeting the same addr are serialized in grant order; the later grant overwrites.
  - The arbiter performs no address hazard checking.
- Back-to-back: one requester may hold req_valid across consecutive cycles. If it is the only requester, it is granted every cycle, so throughput is 1 write/cycle.
- Simultaneous requests: all NUM_REQ requesters valid in the same cycle give exactly one grant and NUM_REQ-1 hold bits high.

Optional Feature:
- Macro: SGPR_ARB_STATS_EN.
- When defined:
  - conflict_cnt increments on every cycle where popcount(req_valid) >= 2.
  - It saturates at 16'hFFFF and is cleared by rst.
- When undefined:
  - The conflict_cnt port and its counter are absent.
  - Arbitration behaviour is identical.

Decomposition:
- Shared package (sgpr_arb_pkg):
  - constants REQ_SALU=0, REQ_VALU=1, REQ_LSU=2;
  - SGPR_ADDR_W=9; WORD_EN_LO=2'b01, WORD_EN_HI=2'b10, WORD_EN_64=2'b11.
- Sub-module: rr_pick, a combinational round-robin one-hot picker.
  - Inputs: req vector and pointer. Output: one-hot winner.
  - Instantiated once; also reusable for the VGPR port.

Test Plan:
- Reset mid-write: SALU req addr=9'h005 data=64'hA, assert rst in that cycle -> next cycle sgpr_wr_en=00, grant=0, rr_ptr=0.
- Single SALU request, addr=9'h010, wr_en=01, data=32'hDEADBEEF -> req_hold[0]=0; next cycle sgpr_wr_en=01, addr=9'h010, grant=001.
- All three requesters valid for 3 cycles from rr_ptr=0 -> grants 001, 010, 100 in order; holds 110, 100, 000; each requester's data appears exactly once.
- rr_ptr=2 with only req 0 and req 2 valid -> req 2 granted first, then req 0 (wrap); rr_ptr returns to 1.
- 64-bit LSU write, wr_en=11, addr=9'h020, data=64'h1122334455667788 -> one cycle, sgpr_wr_en=11, data passed unsplit.
- SGPR_ARB_STATS_EN: 5 cycles with 2+ requesters valid plus 3 single-request cycles -> conflict_cnt=5; preload near 16'hFFFF -> saturates at 16'hFFFF.
